// File: rtl/scan_code_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package scan_code_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SKIP_W = 3;

  localparam logic [BYTE_W-1:0] PREFIX_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PREFIX_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] PREFIX_PAUSE = 8'hE1;
  localparam logic [SKIP_W-1:0] PAUSE_SKIP   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_e;

  // Last make code that reached the display, used for auto-repeat filtering.
  typedef struct packed {
    logic              valid;
    logic              ext;
    logic [BYTE_W-1:0] code;
  } held_key_t;

endpackage

// File: rtl/seq_timeout_timer.sv
// Saturating idle counter; terminal count flags an abandoned multi-byte sequence.
module seq_timeout_timer #(
  parameter int unsigned MAX_COUNT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned         CNT_W   = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over count; hold at the terminal value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/scan_code_sequencer.sv
// PS/2 scan-code sequencer: strips E0/F0/E1 prefixes, emits one shift strobe per
// key press and one break pulse per release.
// Optional build macro: TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the
// currently held key.
module scan_code_sequencer
  import scan_code_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_error,
  output logic              shift_en,
  output logic [BYTE_W-1:0] shift_data,
  output logic              shift_ext,
  output logic              break_pulse,
  output logic [BYTE_W-1:0] break_code,
  output logic              busy
);

  state_e            state_q;
  logic [SKIP_W-1:0] skip_q;

  logic accept_c;
  logic is_prefix_c;
  logic key_ext_c;
  logic make_c;
  logic break_c;
  logic pause_done_c;
  logic suppress_c;
  logic tc_c;
  logic timeout_c;

  // Classify the incoming byte against the current parse state.
  always_comb begin
    accept_c     = rx_valid && !rx_error;
    is_prefix_c  = (rx_data == PREFIX_EXT) || (rx_data == PREFIX_BRK) ||
                   (rx_data == PREFIX_PAUSE);
    key_ext_c    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    make_c       = accept_c &&
                   (((state_q == ST_IDLE) && !is_prefix_c) ||
                    ((state_q == ST_EXT) && (rx_data != PREFIX_BRK)));
    break_c      = accept_c && ((state_q == ST_BRK) || (state_q == ST_EXT_BRK));
    pause_done_c = accept_c && (state_q == ST_PAUSE) && (skip_q == SKIP_W'(1));
    timeout_c    = tc_c && busy && !rx_valid;
  end

  seq_timeout_timer #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (rx_valid),
    .en_i  (busy),
    .tc_o  (tc_c)
  );

`ifdef TYPEMATIC_FILTER_EN
  held_key_t held_q;

  // A make or break matches when it names the same key as the held one.
  always_comb begin
    suppress_c = held_q.valid && (held_q.ext == key_ext_c) && (held_q.code == rx_data);
  end

  // Track the held key: set on a fresh make, cleared by its own break.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
    end else if (make_c && !suppress_c) begin
      held_q <= held_key_t'{valid: 1'b1, ext: key_ext_c, code: rx_data};
    end else if (break_c && suppress_c) begin
      held_q.valid <= 1'b0;
    end
  end
`else
  assign suppress_c = 1'b0;
`endif

  // Prefix parser with registered strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      shift_en    <= 1'b0;
      shift_data  <= '0;
      shift_ext   <= 1'b0;
      break_pulse <= 1'b0;
      break_code  <= '0;
    end else begin
      shift_en    <= 1'b0;
      break_pulse <= 1'b0;

      if (make_c && !suppress_c) begin
        shift_en   <= 1'b1;
        shift_data <= rx_data;
        shift_ext  <= key_ext_c;
      end else if (pause_done_c) begin
        shift_en   <= 1'b1;
        shift_data <= PREFIX_PAUSE;
        shift_ext  <= 1'b0;
      end

      if (break_c) begin
        break_pulse <= 1'b1;
        break_code  <= rx_data;
      end

      if (rx_valid && rx_error) begin
        state_q <= ST_IDLE;
      end else if (rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == PREFIX_EXT) begin
              state_q <= ST_EXT;
            end else if (rx_data == PREFIX_BRK) begin
              state_q <= ST_BRK;
            end else if (rx_data == PREFIX_PAUSE) begin
              state_q <= ST_PAUSE;
              skip_q  <= PAUSE_SKIP;
            end
          end
          ST_EXT:     state_q <= (rx_data == PREFIX_BRK) ? ST_EXT_BRK : ST_IDLE;
          ST_BRK:     state_q <= ST_IDLE;
          ST_EXT_BRK: state_q <= ST_IDLE;
          ST_PAUSE: begin
            skip_q <= skip_q - SKIP_W'(1);
            if (skip_q == SKIP_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
          default:    state_q <= ST_IDLE;
        endcase
      end else if (timeout_c) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Self-checking bench for scan_code_sequencer against a sequence-level model.
module tb_scan_code_sequencer;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       shift_en;
  logic [7:0] shift_data;
  logic       shift_ext;
  logic       break_pulse;
  logic [7:0] break_code;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_shift  = 0;
  int n_break  = 0;
  int gap      = 0;

  logic [7:0] seq_q[$];
`ifdef TYPEMATIC_FILTER_EN
  logic       held_v;
  logic       held_ext;
  logic [7:0] held_code;
`endif

  always #5 clk = ~clk;

  scan_code_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_error    (rx_error),
    .shift_en    (shift_en),
    .shift_data  (shift_data),
    .shift_ext   (shift_ext),
    .break_pulse (break_pulse),
    .break_code  (break_code),
    .busy        (busy)
  );

  task automatic model_clear();
    seq_q.delete();
    gap = 0;
`ifdef TYPEMATIC_FILTER_EN
    held_v = 1'b0;
`endif
  endtask

  // Send one byte, predict its result from the buffered sequence, check the next cycle.
  task automatic send_byte(input string tag, input logic [7:0] b, input logic err);
    logic       e_make, e_brk, e_ext, e_busy;
    logic [7:0] e_code;
    e_make = 1'b0; e_brk = 1'b0; e_ext = 1'b0; e_code = 8'h00;
    if (err) begin
      seq_q.delete();
    end else begin
      seq_q.push_back(b);
      if (seq_q[0] == 8'hE1) begin
        if (seq_q.size() == 8) begin
          e_make = 1'b1; e_code = 8'hE1; seq_q.delete();
        end
      end else if (!((seq_q.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                     (seq_q.size() == 2 && seq_q[0] == 8'hE0 && b == 8'hF0))) begin
        e_ext  = (seq_q[0] == 8'hE0);
        e_brk  = (seq_q[0] == 8'hF0) || (seq_q.size() == 3);
        e_make = !e_brk;
        e_code = b;
        seq_q.delete();
`ifdef TYPEMATIC_FILTER_EN
        if (e_make) begin
          if (held_v && held_ext == e_ext && held_code == b) e_make = 1'b0;
          else begin held_v = 1'b1; held_ext = e_ext; held_code = b; end
        end else if (held_v && held_ext == e_ext && held_code == b) begin
          held_v = 1'b0;
        end
`endif
      end
    end
    e_busy = (seq_q.size() != 0);

    rx_valid = 1'b1; rx_data = b; rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0;
    gap = 0;
    if (shift_en) n_shift++;
    if (break_pulse) n_break++;

    n_checks++;
    if ({shift_en, break_pulse, busy} !== {e_make, e_brk, e_busy}) begin
      n_errors++;
      $display("FAIL %s byte %h strobes: got en/brk/busy=%b%b%b required %b%b%b",
               tag, b, shift_en, break_pulse, busy, e_make, e_brk, e_busy);
    end
    if (e_make) begin
      n_checks++;
      if ({shift_ext, shift_data} !== {e_ext, e_code}) begin
        n_errors++;
        $display("FAIL %s byte %h make: got ext/data=%b/%h required %b/%h",
                 tag, b, shift_ext, shift_data, e_ext, e_code);
      end
    end
    if (e_brk) begin
      n_checks++;
      if (break_code !== e_code) begin
        n_errors++;
        $display("FAIL %s byte %h break_code: got %h required %h", tag, b, break_code, e_code);
      end
    end
  endtask

  // Idle cycles: no strobes; a pending sequence is abandoned after T+1 silent cycles.
  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gap++;
      if (gap == T + 1) seq_q.delete();
      if (shift_en) n_shift++;
      if (break_pulse) n_break++;
      n_checks++;
      if ({shift_en, break_pulse, busy} !== {1'b0, 1'b0, seq_q.size() != 0}) begin
        n_errors++;
        $display("FAIL %s idle %0d: got en/brk/busy=%b%b%b required 00%b",
                 tag, gap, shift_en, break_pulse, busy, seq_q.size() != 0);
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    apply_reset();
    n_checks++;
    if ({shift_en, shift_data, shift_ext, break_pulse, break_code, busy} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_values: got %h required 0",
               {shift_en, shift_data, shift_ext, break_pulse, break_code, busy});
    end
  endtask

  task automatic test_make_break();
    int s0, b0;
    s0 = n_shift; b0 = n_break;
    send_byte("make_break", 8'h1C, 1'b0);
    send_byte("make_break", 8'hF0, 1'b0);
    send_byte("make_break", 8'h1C, 1'b0);
    idle_cycles("make_break", 2);
    n_checks++;
    if (n_shift - s0 != 1 || n_break - b0 != 1) begin
      n_errors++;
      $display("FAIL make_break counts: got shift=%0d break=%0d required 1/1",
               n_shift - s0, n_break - b0);
    end
  endtask

  task automatic test_extended();
    int s0, b0;
    s0 = n_shift; b0 = n_break;
    send_byte("ext", 8'hE0, 1'b0);
    send_byte("ext", 8'h75, 1'b0);
    send_byte("ext", 8'hE0, 1'b0);
    send_byte("ext", 8'hF0, 1'b0);
    send_byte("ext", 8'h75, 1'b0);
    idle_cycles("ext", 2);
    n_checks++;
    if (n_shift - s0 != 1 || n_break - b0 != 1) begin
      n_errors++;
      $display("FAIL ext counts: got shift=%0d break=%0d required 1/1",
               n_shift - s0, n_break - b0);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int s0, b0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    s0 = n_shift; b0 = n_break;
    foreach (seq[i]) send_byte("pause", seq[i], 1'b0);
    idle_cycles("pause", 2);
    n_checks++;
    if (n_shift - s0 != 1 || n_break - b0 != 0) begin
      n_errors++;
      $display("FAIL pause counts: got shift=%0d break=%0d required 1/0",
               n_shift - s0, n_break - b0);
    end
  endtask

  task automatic test_timeout();
    send_byte("timeout", 8'hE0, 1'b0);
    idle_cycles("timeout", T + 2);
    send_byte("timeout", 8'h1C, 1'b0);
    send_byte("timeout_edge", 8'hE0, 1'b0);
    idle_cycles("timeout_edge", T);
    send_byte("timeout_edge", 8'h75, 1'b0);
    idle_cycles("timeout_edge", 2);
  endtask

  task automatic test_error_and_reset();
    send_byte("error", 8'hF0, 1'b1);
    send_byte("error", 8'h32, 1'b0);
    send_byte("reset_mid", 8'hF0, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({shift_en, shift_data, shift_ext, break_pulse, break_code, busy} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_mid outputs: got %h required 0",
               {shift_en, shift_data, shift_ext, break_pulse, break_code, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    send_byte("reset_mid", 8'h32, 1'b0);
    idle_cycles("reset_mid", 2);
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6];
    int s0, b0, e_shift;
    apply_reset();
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    s0 = n_shift; b0 = n_break;
    foreach (seq[i]) send_byte("typematic", seq[i], 1'b0);
    idle_cycles("typematic", 2);
`ifdef TYPEMATIC_FILTER_EN
    e_shift = 2;
`else
    e_shift = 4;
`endif
    n_checks++;
    if (n_shift - s0 != e_shift || n_break - b0 != 1) begin
      n_errors++;
      $display("FAIL typematic counts: got shift=%0d break=%0d required %0d/1",
               n_shift - s0, n_break - b0, e_shift);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] codes [4];
    logic [7:0] b;
    codes = '{8'h1C, 8'h32, 8'h75, 8'h5A};
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = 8'hE1;
        4:       b = 8'($urandom_range(0, 255));
        default: b = codes[$urandom_range(0, 3)];
      endcase
      send_byte("random", b, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 9) == 0) idle_cycles("random", $urandom_range(1, T + 3));
    end
    idle_cycles("random", T + 2);
  endtask

  // Never both strobes in the same cycle.
  always @(negedge clk) begin
    if (!reset && shift_en && break_pulse) begin
      n_checks++;
      n_errors++;
      $display("FAIL exclusive_strobes: got shift_en=1 break_pulse=1 required not both");
    end
  end

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_timeout();
    test_error_and_reset();
    test_typematic();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
